// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide adder sequencer.
package wide_add_pkg;

  // Native word width of the prefix adder core.
  localparam int ADD_WORD_W = 26;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } wa_state_t;

endpackage

// File: rtl/wide_add_seq_if.sv
// Request/response bus of the wide adder sequencer.
interface wide_add_seq_if
  import wide_add_pkg::*;
#(
  parameter int WORD_W = ADD_WORD_W,
  parameter int NWORDS = 4
) ();

  localparam int W = WORD_W * NWORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );

endinterface

// File: rtl/adder.sv
// 26-bit Ling adder with a Kogge-Stone prefix tree over the Ling
// pseudo-carries H[i] = g[i] | c[i-1].
module adder
  import wide_add_pkg::*;
(
  input  logic [ADD_WORD_W-1:0] a,
  input  logic [ADD_WORD_W-1:0] b,
  input  logic                  cin,
  output logic [ADD_WORD_W-1:0] sum,
  output logic                  cout
);

  localparam int N    = ADD_WORD_W;
  localparam int LVLS = $clog2(N);

  logic [N-1:0]           g, p, t, h, c;
  logic [LVLS:0][N-1:0]   x, y;

  // Prefix combine on (x, y) pairs: H[i] = x[i] | y[i] & H[i-1], where
  // y[i] = t[i-1]; cin folds into bit 0 as an extra generate.
  always_comb begin
    g = a & b;
    p = a ^ b;
    t = a | b;
    x = '0;
    y = '0;
    x[0]    = g;
    x[0][0] = g[0] | cin;
    y[0]    = {t[N-2:0], 1'b0};
    for (int lvl = 1; lvl <= LVLS; lvl++) begin
      for (int i = 0; i < N; i++) begin
        if (i >= (1 << (lvl - 1))) begin
          x[lvl][i] = x[lvl-1][i] | (y[lvl-1][i] & x[lvl-1][i - (1 << (lvl - 1))]);
          y[lvl][i] = y[lvl-1][i] & y[lvl-1][i - (1 << (lvl - 1))];
        end else begin
          x[lvl][i] = x[lvl-1][i];
          y[lvl][i] = y[lvl-1][i];
        end
      end
    end
    h    = x[LVLS];
    c    = t & h;
    sum  = p ^ {c[N-2:0], cin};
    cout = c[N-1];
  end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: walks NWORDS words through one 26-bit adder,
// LSW first, with the carry chained through a register between words.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int WORD_W = ADD_WORD_W,  // must equal ADD_WORD_W
  parameter int NWORDS = 4            // >= 2
) (
  input logic          clk,
  input logic          rst,
  wide_add_seq_if.slave bus
);

  localparam int W     = WORD_W * NWORDS;
  localparam int IDX_W = $clog2(NWORDS);

  wa_state_t          state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [W-1:0]       sum_q, sum_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;

  logic [WORD_W-1:0]  a_word, b_word, add_sum;
  logic               add_cout;

  // Select the current operand word from the latched operands.
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (int'(idx_q) == k) begin
        a_word = a_q[k*WORD_W +: WORD_W];
        b_word = b_q[k*WORD_W +: WORD_W];
      end
    end
  end

  // Carry input comes only from the carry register, never from in_cin.
  adder u_adder (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < NWORDS; k++) begin
          if (int'(idx_q) == k) sum_d[k*WORD_W +: WORD_W] = add_sum;
        end
        carry_d = add_cout;
        if (int'(idx_q) == NWORDS - 1) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      sum_q   <= sum_d;
    end
  end

  // Operand latches; contents are only meaningful after an accept.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;

endmodule
